cla_addsub_pipe: RTL
====================

# cla_addsub_pipe

Parametrised, pipelined carry-lookahead adder/subtractor. It is the next generation of the team's 4-bit combinational CLA, generalised to any WIDTH that is a multiple of the lookahead group size BLOCK. Each pipeline stage resolves one BLOCK-bit group with full internal lookahead, using the group carry registered by the previous stage. The block adds a subtract mode, a signed-overflow flag, and a valid/ready stream handshake with backpressure, so it can sit in streaming datapaths that need one add per cycle at high clock rates.

## Interface
- WIDTH, 16: operand/result width; must be a multiple of BLOCK.
- BLOCK, 4: lookahead group width, 1..8. Any other value, or WIDTH % BLOCK != 0, is an elaboration error.
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset; synchronous and active-high.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block accepts a beat this cycle.
- a  in  WIDTH  operand A (unsigned or two's complement).
- b  in  WIDTH  operand B.
- cin  in  1  carry-in; ignored when sub=1.
- sub  in  1  0: a+b+cin; 1: a-b.
- out_valid  out  1  result beat present.
- out_ready  in  1  downstream accepts the result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- cout  out  1  carry out of MSB (for sub: 1 = no borrow).
- ovf  out  1  signed overflow.

## Operation
- N = WIDTH/BLOCK stages. Stage k computes result bits [k*BLOCK +: BLOCK] from:
  - per-bit P = a^b' and G = a&b', where b' = sub ? ~b : b;
  - group carries in lookahead form, with no ripple inside a group;
  - the registered carry from stage k-1. Stage 0 uses c0 = sub ? 1 : cin.
- Operand bits above the current group travel down the pipeline skewed. Completed low result bits travel alongside them.
- Stage N-1 registers:
  - sum;
  - cout = carry out of bit WIDTH-1;
  - ovf = (carry into bit WIDTH-1) ^ cout.
- Each stage holds a valid bit. A beat is accepted on a clock edge where in_valid && in_ready.
- Stall is global. stall = out_valid && !out_ready.
  - When stall is high, every stage register, including the valid bits, holds its value.
  - in_ready = !stall (combinational from out_valid and out_ready).
- When stall is low, valids shift every cycle. Bubbles (in_valid=0) propagate as valid=0 slots.
- Results leave in acceptance order. There is no reordering, dropping or duplication.
- sum, cout and ovf are only meaningful while out_valid=1. They must hold stable while out_valid && !out_ready.

## Timing
- Latency: a beat accepted at edge T appears with out_valid=1 after edge T+N-1, i.e. N cycles from acceptance to the first cycle it is presented. With N=1 the result is registered one edge after acceptance.
- Throughput: one beat per cycle when out_ready is held high.
- Reset, sampled on a clk edge with rst=1:
  - all stage valid bits clear, so out_valid=0 after that edge;
  - sum, cout, ovf and all internal carry/data registers clear to 0;
  - in_ready=1 after reset.
- Reset mid-operation discards every in-flight beat. No result from before reset may appear afterwards.
- A beat offered in the same cycle as rst=1 is not accepted.
- Simultaneous accept and emit (in_valid, out_valid and out_ready all high) is legal and loses nothing.
- A stall that begins with empty stages behind the output still freezes the whole pipe. Bubbles are not compressed.

## Test plan
Use WIDTH=16, BLOCK=4 (N=4) unless stated otherwise.
- 0xFFFF + 0x0001, cin=0, sub=0 -> after 4 cycles: sum=0x0000, cout=1, ovf=0. Also 0x1234 + 0x0000, cin=1 -> sum=0x1235, cout=0, ovf=0.
- 0x7FFF + 0x0001, sub=0 -> sum=0x8000, cout=0, ovf=1. 0x8000 + 0x8000 -> sum=0x0000, cout=1, ovf=1.
- Subtract mode:
  - 0x0005 - 0x0007 -> sum=0xFFFE, cout=0, ovf=0.
  - 0x8000 - 0x0001 -> sum=0x7FFF, cout=1, ovf=1.
  - cin=1 with sub=1 has no effect on the result.
- Stream 200 random beats with random in_valid gaps and out_ready toggling at random -> every result matches the reference model, in order, with none lost or duplicated. While out_valid && !out_ready, in_ready=0 and the outputs are stable.
- Accept 3 beats, then pulse rst for one cycle -> out_valid=0 after the reset edge. None of the 3 results ever appear. The next accepted beat emerges 4 cycles later and is correct.
- WIDTH=8, BLOCK=8 (N=1) and WIDTH=8, BLOCK=1 (N=8): exhaustive a, b, cin, sub (2^18 beats) at full rate -> all match, with latency 1 and 8 respectively.

Source files
------------

// File: rtl/cla_addsub_pipe.sv
`default_nettype none
// ============================================================================
// Module   : cla_addsub_pipe
// Purpose  : Pipelined carry-lookahead adder/subtractor. Each stage resolves
//            one BLOCK-bit group with flattened lookahead carries, taking the
//            group carry-in from the previous stage's register. The handshake
//            is valid/ready with a single global stall.
// Revision : 1.0 - initial release
// ============================================================================
module cla_addsub_pipe #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N = WIDTH / BLOCK;

    if ((BLOCK < 1) || (BLOCK > 8) || ((WIDTH % BLOCK) != 0)) begin : g_param_check
        $error("cla_addsub_pipe: BLOCK must be 1..8 and WIDTH a multiple of BLOCK");
    end

    // Per-stage registered outputs, indexed by stage number
    logic             w_vo [N];
    logic             w_co [N];
    logic [WIDTH-1:0] w_ao [N];
    logic [WIDTH-1:0] w_bo [N];
    logic [WIDTH-1:0] w_so [N];

    logic             w_stall;
    logic             r_ovf;
    logic             w_unused;

    // A presented-but-unaccepted result freezes the whole pipe, bubbles included
    assign w_stall   = w_vo[N-1] & ~out_ready;
    assign in_ready  = ~w_stall;
    assign out_valid = w_vo[N-1];
    assign sum       = w_so[N-1];
    assign cout      = w_co[N-1];
    assign ovf       = r_ovf;

    // Operand copies leaving the final stage have no consumer
    assign w_unused  = ^{w_ao[N-1], w_bo[N-1]};

    for (genvar k = 0; k < N; k++) begin : g_stage
        logic             w_vi;
        logic             w_ci;
        logic [WIDTH-1:0] w_ai;
        logic [WIDTH-1:0] w_bi;
        logic [WIDTH-1:0] w_si;
        logic [BLOCK-1:0] w_p;
        logic [BLOCK-1:0] w_g;
        logic [BLOCK:0]   w_c;
        logic             w_t;
        logic [WIDTH-1:0] w_snew;

        logic             r_vld;
        logic             r_cy;
        logic [WIDTH-1:0] r_a;
        logic [WIDTH-1:0] r_b;
        logic [WIDTH-1:0] r_s;

        if (k == 0) begin : g_head
            // Subtraction is a + ~b + 1; cin is ignored in that mode
            assign w_vi = in_valid;
            assign w_ci = sub | cin;
            assign w_ai = a;
            assign w_bi = b ^ {WIDTH{sub}};
            assign w_si = '0;
        end else begin : g_body
            assign w_vi = w_vo[k-1];
            assign w_ci = w_co[k-1];
            assign w_ai = w_ao[k-1];
            assign w_bi = w_bo[k-1];
            assign w_si = w_so[k-1];
        end

        // Group lookahead: every carry is a flat sum of products of G, P and group carry-in
        always_comb begin
            w_p    = w_ai[k*BLOCK +: BLOCK] ^ w_bi[k*BLOCK +: BLOCK];
            w_g    = w_ai[k*BLOCK +: BLOCK] & w_bi[k*BLOCK +: BLOCK];
            w_c    = '0;
            w_t    = 1'b0;
            for (int i = 0; i <= BLOCK; i++) begin
                w_c[i] = w_ci;
                for (int m = 0; m < i; m++) begin
                    w_c[i] = w_c[i] & w_p[m];
                end
                for (int j = 0; j < i; j++) begin
                    w_t = w_g[j];
                    for (int m = j + 1; m < i; m++) begin
                        w_t = w_t & w_p[m];
                    end
                    w_c[i] = w_c[i] | w_t;
                end
            end
            w_snew = w_si;
            w_snew[k*BLOCK +: BLOCK] = w_p ^ w_c[BLOCK-1:0];
        end

        // Stage register: advances only when the output is not stalled
        always_ff @(posedge clk) begin
            if (rst) begin
                r_vld <= 1'b0;
                r_cy  <= 1'b0;
                r_a   <= '0;
                r_b   <= '0;
                r_s   <= '0;
            end else if (!w_stall) begin
                r_vld <= w_vi;
                r_cy  <= w_c[BLOCK];
                r_a   <= w_ai;
                r_b   <= w_bi;
                r_s   <= w_snew;
            end
        end

        assign w_vo[k] = r_vld;
        assign w_co[k] = r_cy;
        assign w_ao[k] = r_a;
        assign w_bo[k] = r_b;
        assign w_so[k] = r_s;

        if (k == N - 1) begin : g_tail
            // Signed overflow: carry into the MSB differs from carry out of it
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_ovf <= 1'b0;
                end else if (!w_stall) begin
                    r_ovf <= w_c[BLOCK-1] ^ w_c[BLOCK];
                end
            end
        end
    end

endmodule
`default_nettype wire
